// File: rtl/ram_burst_master_if.sv
// Bundle of burst-command, write/read stream, RAM and status signals for ram_burst_master.
// master = the burst master itself, slave = its environment (producer/consumer + RAM).
interface ram_burst_master_if #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int LW = 6
);
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          busy, done;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ram_q,
    output cmd_ready, wr_ready, rd_data, rd_valid, ram_data, ram_addr, ram_we, busy, done
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, ram_q,
    input  cmd_ready, wr_ready, rd_data, rd_valid, ram_data, ram_addr, ram_we, busy, done
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst master for a single-port RAM with registered q: turns burst commands plus write/read
// streams into RAM cycles; reads land in a 4-entry buffer guarded by a credit rule.
module ram_burst_master #(
  parameter int DW = 8,
  parameter int AW = 6,
  parameter int LW = 6
) (
  input logic               clk,
  input logic               rst_n,
  ram_burst_master_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FINISH} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cur_q, cur_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW:0]         beat_q, beat_d;
  logic [LW:0]         pop_cnt_q, pop_cnt_d;
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [DW-1:0]       ram_data_q, ram_data_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [3:0][DW-1:0]  fifo_q, fifo_d;
  logic [1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]          occ_q, occ_d;
  logic [DW-1:0]       hold_q, hold_d;

  logic       rd_valid, push, pop, issue_ok;
  logic [1:0] inflight;

  assign rd_valid = (occ_q != 3'd0);
  assign pop      = rd_valid & bus.rd_ready;
  // vld_pipe_q[1] marks that ram_q now holds the word addressed two edges ago
  assign push     = vld_pipe_q[1];
  assign inflight = 2'(vld_pipe_q[0]) + 2'(vld_pipe_q[1]);
  // credit: buffered + in-flight words never exceed the 4 buffer slots
  assign issue_ok = (beat_q <= {1'b0, len_q}) &&
                    (({1'b0, occ_q} + {2'b00, inflight}) < 4'd4);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    beat_d     = beat_q;
    pop_cnt_d  = pop_cnt_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b0};
    ram_data_d = ram_data_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    hold_d     = hold_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cur_d     = bus.cmd_addr;
          len_d     = bus.cmd_len;
          beat_d    = '0;
          pop_cnt_d = '0;
          state_d   = bus.cmd_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (bus.wr_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = cur_q;
          ram_data_d = bus.wr_data;
          cur_d      = cur_q + 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == {1'b0, len_q}) state_d = S_FINISH;
        end
      end
      S_READ: begin
        if (issue_ok) begin
          ram_addr_d    = cur_q;
          cur_d         = cur_q + 1'b1;
          beat_d        = beat_q + 1'b1;
          vld_pipe_d[0] = 1'b1;
        end
        if (pop && pop_cnt_q == {1'b0, len_q}) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = bus.ram_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (rd_valid) hold_d = fifo_q[rd_ptr_q];
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      pop_cnt_d = pop_cnt_q + 1'b1;
    end
    occ_d = occ_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      pop_cnt_q  <= '0;
      vld_pipe_q <= '0;
      ram_data_q <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pop_cnt_q  <= pop_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      ram_data_q <= ram_data_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_WRITE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.rd_valid  = rd_valid;
  // rd_data keeps the last shown head once the buffer drains
  assign bus.rd_data   = rd_valid ? fifo_q[rd_ptr_q] : hold_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master: expected RAM writes and read beats are queued by the
// stimulus and popped by a negedge monitor; a behavioural single-port RAM closes the loop.
module tb_ram_burst_master;
  localparam int DW = 8, AW = 6, LW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_master_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();
  ram_burst_master #(.DW(DW), .AW(AW), .LW(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // single-port RAM, registered q
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_addr];
  end

  int nvec = 0, nerr = 0;
  int done_cnt = 0, we_cnt = 0;
  logic [DW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    dv [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: sampled on the falling edge, midway between active edges
  initial forever begin
    @(negedge clk);
    if (bus.done) done_cnt++;
    if (bus.rd_valid && bus.rd_ready) begin
      if (exp_rd.size() == 0) chk("rd_unexpected_beat", {24'd0, bus.rd_data}, 32'hFFFF_FFFF);
      else chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_rd.pop_front()});
    end
    if (bus.ram_we) begin
      we_cnt++;
      if (exp_wr.size() == 0) chk("ram_we_unexpected", {18'd0, bus.ram_addr, bus.ram_data}, 32'hFFFF_FFFF);
      else chk("ram_wr_addr_data", {18'd0, bus.ram_addr, bus.ram_data}, {18'd0, exp_wr.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {26'd0, bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.ram_we},
        32'b100000);
    chk({nm, "_ram"}, {18'd0, bus.ram_addr, bus.ram_data}, 32'd0);
    chk({nm, "_rd_data"}, {24'd0, bus.rd_data}, 32'd0);
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int k;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    if (k == 50) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk(nm, 32'(k < 400), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int l, input int gap);
    for (int i = 0; i <= l; i++) exp_wr.push_back({AW'(int'(a) + i), dv[i]});
    send_cmd(1'b1, a, LW'(l));
    for (int i = 0; i <= l; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = dv[i];
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    wait_idle("wr_burst_end_timeout");
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int l);
    for (int i = 0; i <= l; i++) exp_rd.push_back(dv[i]);
    send_cmd(1'b0, a, LW'(l));
    wait_idle("rd_burst_end_timeout");
  endtask

  initial begin
    int dc, wc, k, run;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0;  bus.wr_data = '0;  bus.rd_ready = 1'b1;

    repeat (2) @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write 01,02,03 at 0..2
    dv[0] = 8'h01; dv[1] = 8'h02; dv[2] = 8'h03;
    dc = done_cnt; wc = we_cnt;
    wr_burst(6'd0, 2, 0);
    chk("t1_we_pulses", 32'(we_cnt - wc), 32'd3);
    chk("t1_done", 32'(done_cnt - dc), 32'd1);

    // 2: read back, first beat 3 edges after the accepting edge, then back-to-back
    dc = done_cnt;
    for (int i = 0; i < 3; i++) exp_rd.push_back(dv[i]);
    send_cmd(1'b0, 6'd0, 6'd2);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rd_valid) break;
    end
    chk("t2_first_beat_latency", 32'(k), 32'd3);
    run = 1;
    repeat (2) begin
      @(negedge clk);
      if (bus.rd_valid) run++;
    end
    chk("t2_back_to_back", 32'(run), 32'd3);
    @(posedge clk); #1;
    wait_idle("t2_end_timeout");
    chk("t2_done", 32'(done_cnt - dc), 32'd1);

    // 3: gapped write beats
    dv[0] = 8'h04; dv[1] = 8'h05;
    dc = done_cnt; wc = we_cnt;
    wr_burst(6'd1, 1, 3);
    chk("t3_we_pulses", 32'(we_cnt - wc), 32'd2);
    chk("t3_done", 32'(done_cnt - dc), 32'd1);

    // 6: reset mid read burst with an ignored command; memory must survive
    dc = done_cnt; wc = we_cnt;
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 6'd0, 6'd7);
    repeat (3) begin @(posedge clk); #1; end
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 6'd30; bus.cmd_len = 6'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("t6_busy_before_reset", 32'(bus.busy), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("t6_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rd_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("t6_idle_after_reset", {30'd0, bus.busy, bus.cmd_ready}, 32'b01);
    chk("t6_no_write_no_done", 32'((we_cnt - wc) + (done_cnt - dc)), 32'd0);
    dv[0] = 8'h01; dv[1] = 8'h04; dv[2] = 8'h05;
    rd_burst(6'd0, 2);
    chk("t6_done", 32'(done_cnt - dc), 32'd1);

    // 4: address wrap 62,63,0,1
    dv[0] = 8'hA0; dv[1] = 8'hA1; dv[2] = 8'hA2; dv[3] = 8'hA3;
    wr_burst(6'd62, 3, 0);
    rd_burst(6'd62, 3);

    // 5: 8-beat read with consumer stalled; only 4 addresses may go out
    for (int i = 0; i < 8; i++) dv[i] = 8'(8'h10 + i);
    wr_burst(6'd8, 7, 0);
    for (int i = 0; i < 8; i++) exp_rd.push_back(dv[i]);
    bus.rd_ready = 1'b0;
    dc = done_cnt;
    send_cmd(1'b0, 6'd8, 6'd7);
    repeat (10) begin @(posedge clk); #1; end
    chk("t5_last_issued_addr", 32'(bus.ram_addr), 32'd11);
    chk("t5_stalled_valid", {31'd0, bus.rd_valid}, 32'd1);
    bus.rd_ready = 1'b1;
    wait_idle("t5_end_timeout");
    chk("t5_done", 32'(done_cnt - dc), 32'd1);

    // max length: 64 beats from 5, wrapping
    for (int i = 0; i < 64; i++) dv[i] = 8'(i * 7 + 3);
    wc = we_cnt; dc = done_cnt;
    wr_burst(6'd5, 63, 0);
    chk("t7_we_pulses", 32'(we_cnt - wc), 32'd64);
    rd_burst(6'd5, 63);
    chk("t7_done", 32'(done_cnt - dc), 32'd2);

    repeat (3) begin @(posedge clk); #1; end
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
